// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants, ALUOp/ImmSrc/ResultSrc encodings and the control word shared by the decode stage
package decode_pkg;

    localparam int CTRL_W = 14;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_BEQ    = 3'b001;
    localparam logic [2:0] ALU_RTYPE  = 3'b010;
    localparam logic [2:0] ALU_SHIFT  = 3'b011;
    localparam logic [2:0] ALU_BLT    = 3'b100;
    localparam logic [2:0] ALU_BLTU   = 3'b101;
    localparam logic [2:0] ALU_MULDIV = 3'b110;

    localparam logic [2:0] IMM_I  = 3'b000;
    localparam logic [2:0] IMM_S  = 3'b001;
    localparam logic [2:0] IMM_B  = 3'b010;
    localparam logic [2:0] IMM_J  = 3'b011;
    localparam logic [2:0] IMM_U  = 3'b100;
    localparam logic [2:0] IMM_SH = 3'b101;

    localparam logic [1:0] RES_ALU   = 2'b00;
    localparam logic [1:0] RES_MEM   = 2'b01;
    localparam logic [1:0] RES_PC4   = 2'b10;
    localparam logic [1:0] RES_UPPER = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic [2:0] imm_src;
        logic       alu_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic [2:0] alu_op;
        logic       jump;
        logic       jalr;
    } ctrl_t;

    function automatic ctrl_t mk_ctrl(
        input logic       reg_write,
        input logic [2:0] imm_src,
        input logic       alu_src,
        input logic       mem_write,
        input logic [1:0] result_src,
        input logic       branch,
        input logic [2:0] alu_op,
        input logic       jump,
        input logic       jalr
    );
        return '{reg_write, imm_src, alu_src, mem_write, result_src, branch, alu_op, jump, jalr};
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational RV32I(+M) instruction to control-word decoder with illegal detection
module ctrl_decode
    import decode_pkg::*;
#(
    parameter int M_EXT = 1
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        illegal_o
);

    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       shift;
    ctrl_t      raw;
    logic       ill;

    assign op     = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign shift  = funct3[1:0] == 2'b01;

    // Raw control word per opcode; undefined encodings only raise ill
    always_comb begin
        raw = '0;
        ill = 1'b0;
        case (op)
            OP_LOAD:   raw = mk_ctrl(1'b1, IMM_I, 1'b1, 1'b0, RES_MEM, 1'b0, ALU_ADD, 1'b0, 1'b0);
            OP_STORE:  raw = mk_ctrl(1'b0, IMM_S, 1'b1, 1'b1, RES_ALU, 1'b0, ALU_ADD, 1'b0, 1'b0);
            OP_REG: begin
                if (M_EXT != 0 && funct7 == F7_MULDIV)
                    raw = mk_ctrl(1'b1, IMM_I, 1'b0, 1'b0, RES_ALU, 1'b0, ALU_MULDIV, 1'b0, 1'b0);
                else if (funct7 == F7_BASE || funct7 == F7_ALT)
                    raw = mk_ctrl(1'b1, IMM_I, 1'b0, 1'b0, RES_ALU, 1'b0, shift ? ALU_SHIFT : ALU_RTYPE, 1'b0, 1'b0);
                else
                    ill = 1'b1;
            end
            OP_IMM:    raw = mk_ctrl(1'b1, shift ? IMM_SH : IMM_I, 1'b1, 1'b0, RES_ALU, 1'b0,
                                     shift ? ALU_SHIFT : ALU_RTYPE, 1'b0, 1'b0);
            OP_BRANCH: begin
                ill = funct3[2:1] == 2'b01;
                raw = mk_ctrl(1'b0, IMM_B, 1'b0, 1'b0, RES_ALU, 1'b1,
                              funct3[2] ? (funct3[1] ? ALU_BLTU : ALU_BLT) : ALU_BEQ, 1'b0, 1'b0);
            end
            OP_JAL:    raw = mk_ctrl(1'b1, IMM_J, 1'b0, 1'b0, RES_PC4, 1'b0, ALU_ADD, 1'b1, 1'b0);
            OP_LUI,
            OP_AUIPC:  raw = mk_ctrl(1'b1, IMM_U, 1'b0, 1'b0, RES_UPPER, 1'b0, ALU_ADD, 1'b0, 1'b0);
            OP_JALR:   raw = mk_ctrl(1'b1, IMM_I, 1'b1, 1'b0, RES_PC4, 1'b0, ALU_ADD, 1'b0, 1'b1);
            default:   ill = 1'b1;
        endcase
    end

    assign illegal_o = ill;
    assign ctrl_o    = ill ? '0 : raw;

endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered decode stage with valid/ready handshake, optional 2-entry skid buffer and flush
module decode_ctrl_stage
    import decode_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int M_EXT = 1,
    parameter int SKID  = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic            RegWrite,
    output logic [2:0]      ImmSrc,
    output logic            ALUSrc,
    output logic            MemWrite,
    output logic [1:0]      ResultSrc,
    output logic            Branch,
    output logic [2:0]      ALUOp,
    output logic            Jump,
    output logic            Jalr,
    output logic            Illegal
);

    ctrl_t           dec_ctrl;
    logic            dec_ill;
    logic            in_fire;
    logic            out_free;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic [PC_W-1:0] out_pc_q, out_pc_d;
    ctrl_t           out_ctrl_q, out_ctrl_d;
    logic            out_ill_q, out_ill_d;
    logic            skid_valid_q, skid_valid_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;
    ctrl_t           skid_ctrl_q, skid_ctrl_d;
    logic            skid_ill_q, skid_ill_d;
    logic            in_ready_q, in_ready_d;

    ctrl_decode #(.M_EXT(M_EXT)) u_ctrl_decode (
        .instr_i   (in_instr),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_ill)
    );

    // in_ready_q doubles as "out of reset"; without a skid it gates the combinational ready
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (SKID != 0) ? in_ready_q : in_ready_q && out_free;
    assign in_fire  = in_valid && in_ready;

    // Flush wins; otherwise the skid drains into a free output, else a new entry fills the output or the skid
    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_ctrl_d   = out_ctrl_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_ill_d   = skid_ill_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free && skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_instr_d  = skid_instr_q;
            out_pc_d     = skid_pc_q;
            out_ctrl_d   = skid_ctrl_q;
            out_ill_d    = skid_ill_q;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            out_valid_d = in_fire;
            out_instr_d = in_fire ? in_instr : out_instr_q;
            out_pc_d    = in_fire ? in_pc : out_pc_q;
            out_ctrl_d  = in_fire ? dec_ctrl : out_ctrl_q;
            out_ill_d   = in_fire ? dec_ill : out_ill_q;
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_instr_d = in_instr;
            skid_pc_d    = in_pc;
            skid_ctrl_d  = dec_ctrl;
            skid_ill_d   = dec_ill;
        end
        in_ready_d = (SKID != 0) ? !skid_valid_d : 1'b1;
    end

    // State registers, cleared to zero by the synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            out_ctrl_q   <= '0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_ctrl_q  <= '0;
            skid_ill_q   <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_ctrl_q   <= out_ctrl_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_ill_q   <= skid_ill_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign RegWrite  = out_ctrl_q.reg_write;
    assign ImmSrc    = out_ctrl_q.imm_src;
    assign ALUSrc    = out_ctrl_q.alu_src;
    assign MemWrite  = out_ctrl_q.mem_write;
    assign ResultSrc = out_ctrl_q.result_src;
    assign Branch    = out_ctrl_q.branch;
    assign ALUOp     = out_ctrl_q.alu_op;
    assign Jump      = out_ctrl_q.jump;
    assign Jalr      = out_ctrl_q.jalr;
    assign Illegal   = out_ill_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: table-driven scoreboard bench for decode_ctrl_stage (M_EXT=1/SKID=1 and M_EXT=0/SKID=0)
module tb_decode_ctrl_stage;

    typedef struct {
        logic [31:0] instr;
        logic [14:0] exp;
        logic        ill_m0;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [14:0] ctl;
    } sb_t;

    localparam int NV = 19;
    localparam logic [14:0] ILL_CTL = 15'b0_000_0_0_00_0_000_0_0_1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, RegWrite, ALUSrc, MemWrite, Branch, Jump, Jalr, Illegal;
    logic [31:0] out_instr, out_pc;
    logic [2:0]  ImmSrc, ALUOp;
    logic [1:0]  ResultSrc;
    logic        in_ready0, out_valid0, RegWrite0, ALUSrc0, MemWrite0, Branch0, Jump0, Jalr0, Illegal0;
    logic [31:0] out_instr0, out_pc0;
    logic [2:0]  ImmSrc0, ALUOp0;
    logic [1:0]  ResultSrc0;
    logic [14:0] ctl1, ctl0;

    vec_t        vecs [NV];
    sb_t         q1 [$];
    sb_t         q0 [$];
    logic [14:0] exp_ctl, exp_ctl0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    decode_ctrl_stage #(.PC_W(32), .M_EXT(1), .SKID(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .RegWrite(RegWrite),
        .ImmSrc(ImmSrc), .ALUSrc(ALUSrc), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
        .Branch(Branch), .ALUOp(ALUOp), .Jump(Jump), .Jalr(Jalr), .Illegal(Illegal)
    );

    decode_ctrl_stage #(.PC_W(32), .M_EXT(0), .SKID(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid0),
        .out_ready(out_ready), .out_instr(out_instr0), .out_pc(out_pc0), .RegWrite(RegWrite0),
        .ImmSrc(ImmSrc0), .ALUSrc(ALUSrc0), .MemWrite(MemWrite0), .ResultSrc(ResultSrc0),
        .Branch(Branch0), .ALUOp(ALUOp0), .Jump(Jump0), .Jalr(Jalr0), .Illegal(Illegal0)
    );

    assign ctl1 = {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump, Jalr, Illegal};
    assign ctl0 = {RegWrite0, ImmSrc0, ALUSrc0, MemWrite0, ResultSrc0, Branch0, ALUOp0, Jump0, Jalr0, Illegal0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: sampled mid-cycle, describes what the next rising edge will transfer
    always @(negedge clk) begin
        sb_t e;
        if (!reset_n) begin
            q1.delete();
            q0.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q1.size() == 0) begin
                    check("unexpected_out", {32'd0, out_instr}, 64'hDEAD_0000_0000_0000);
                end else begin
                    e = q1.pop_front();
                    check("out_instr", out_instr, e.instr);
                    check("out_pc", out_pc, e.pc);
                    check("ctrl", ctl1, e.ctl);
                end
            end
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) begin
                    check("unexpected_out_m0", {32'd0, out_instr0}, 64'hDEAD_0000_0000_0000);
                end else begin
                    e = q0.pop_front();
                    check("out_instr_m0", out_instr0, e.instr);
                    check("out_pc_m0", out_pc0, e.pc);
                    check("ctrl_m0", ctl0, e.ctl);
                end
            end
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (in_valid && in_ready) q1.push_back('{in_instr, in_pc, exp_ctl});
                if (in_valid && in_ready0) q0.push_back('{in_instr, in_pc, exp_ctl0});
            end
        end
    end

    task automatic drive(input int idx, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = vecs[idx].instr;
        in_pc    = pc;
        exp_ctl  = vecs[idx].exp;
        exp_ctl0 = vecs[idx].ill_m0 ? ILL_CTL : vecs[idx].exp;
    endtask

    task automatic send(input int idx, input logic [31:0] pc);
        logic r;
        int   k;
        k = 0;
        drive(idx, pc);
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            k++;
        end while (!r && k < 50);
        if (!r) check("send_timeout", r, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (q1.size() == 0 && q0.size() == 0 && !out_valid && !out_valid0) break;
            @(posedge clk);
            #1;
        end
        check("drain", q1.size() + q0.size(), 0);
    endtask

    initial begin
        vecs[0]  = '{32'h00412083, 15'b1_000_1_0_01_0_000_0_0_0, 1'b0};
        vecs[1]  = '{32'h00112223, 15'b0_001_1_1_00_0_000_0_0_0, 1'b0};
        vecs[2]  = '{32'h002081B3, 15'b1_000_0_0_00_0_010_0_0_0, 1'b0};
        vecs[3]  = '{32'h002091B3, 15'b1_000_0_0_00_0_011_0_0_0, 1'b0};
        vecs[4]  = '{32'h4020D1B3, 15'b1_000_0_0_00_0_011_0_0_0, 1'b0};
        vecs[5]  = '{32'h02208033, 15'b1_000_0_0_00_0_110_0_0_0, 1'b1};
        vecs[6]  = '{32'h00108093, 15'b1_000_1_0_00_0_010_0_0_0, 1'b0};
        vecs[7]  = '{32'h00209093, 15'b1_101_1_0_00_0_011_0_0_0, 1'b0};
        vecs[8]  = '{32'h00208463, 15'b0_010_0_0_00_1_001_0_0_0, 1'b0};
        vecs[9]  = '{32'h0020C463, 15'b0_010_0_0_00_1_100_0_0_0, 1'b0};
        vecs[10] = '{32'h0020F463, 15'b0_010_0_0_00_1_101_0_0_0, 1'b0};
        vecs[11] = '{32'h0020A063, ILL_CTL, 1'b0};
        vecs[12] = '{32'h008000EF, 15'b1_011_0_0_10_0_000_1_0_0, 1'b0};
        vecs[13] = '{32'h123450B7, 15'b1_100_0_0_11_0_000_0_0_0, 1'b0};
        vecs[14] = '{32'h00001097, 15'b1_100_0_0_11_0_000_0_0_0, 1'b0};
        vecs[15] = '{32'h000080E7, 15'b1_000_1_0_10_0_000_0_1_0, 1'b0};
        vecs[16] = '{32'h202081B3, ILL_CTL, 1'b0};
        vecs[17] = '{32'h0000007F, ILL_CTL, 1'b0};
        vecs[18] = '{32'h00000000, ILL_CTL, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_ctl", ctl1, 15'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_in_ready_m0", in_ready0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", in_ready, 1'b1);

        out_ready = 1'b1;
        send(0, 32'h100);
        check("lw_valid", out_valid, 1'b1);
        check("lw_ctl", ctl1, 15'b1_000_1_0_01_0_000_0_0_0);
        send(5, 32'h104);
        check("mul_ctl", ctl1, 15'b1_000_0_0_00_0_110_0_0_0);
        check("mul_ctl_m0", ctl0, ILL_CTL);
        for (int i = 0; i < NV; i++) send(i, 32'h1000 + 32'(i) * 4);
        drain();

        out_ready = 1'b0;
        send(2, 32'h200);
        check("sk_a_valid", out_valid, 1'b1);
        check("sk_m0_ready", in_ready0, 1'b0);
        send(3, 32'h204);
        check("sk_in_ready", in_ready, 1'b0);
        check("sk_hold_a", out_instr, vecs[2].instr);
        @(posedge clk);
        #1;
        check("sk_stable", {out_valid, out_instr, ctl1}, {1'b1, vecs[2].instr, vecs[2].exp});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("sk_b_next", {out_valid, out_instr}, {1'b1, vecs[3].instr});
        check("sk_ready_back", in_ready, 1'b1);
        @(posedge clk);
        #1;
        check("sk_empty", out_valid, 1'b0);
        drain();

        out_ready = 1'b0;
        send(6, 32'h300);
        send(7, 32'h304);
        drive(8, 32'h308);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", out_valid, 1'b0);
        check("fl_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("fl_quiet", out_valid, 1'b0);
        out_ready = 1'b0;
        send(9, 32'h400);
        drive(10, 32'h404);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl1_out_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        send(12, 32'h408);
        drain();

        out_ready = 1'b0;
        send(13, 32'h500);
        send(14, 32'h504);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("mr_out_valid", out_valid, 1'b0);
        check("mr_instr", out_instr, 32'd0);
        check("mr_in_ready", in_ready, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("mr_rel_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mr_quiet", out_valid, 1'b0);
        send(15, 32'h600);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
